irq_event_coalescer: RTL

//  Upstream feeder of the IRQ generator. Captures raw per-source events (level or rising edge),

---
 rtl/irq_pkg.sv | 14 +
 rtl/irq_edge_detect.sv | 27 ++
 rtl/irq_event_coalescer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and default widths for the interrupt path (irq_event_coalescer, irq_gen).
package irq_pkg;

  localparam int SRC_W_DEF = 32;
  localparam int CNT_W_DEF = 8;
  localparam int TMO_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } coal_state_t;

endpackage

// File: rtl/irq_edge_detect.sv
// Per-bit event qualifier: level mode passes every high cycle, edge mode passes only 0->1 transitions.
module irq_edge_detect
  import irq_pkg::*;
#(
  parameter int W = SRC_W_DEF
) (
  input  logic         clk,
  input  logic         srst_n,
  input  logic [W-1:0] evt,
  input  logic [W-1:0] edge_mode,
  output logic [W-1:0] new_evt
);

  logic [W-1:0] evt_q;

  // Cleared in reset so a level still high at release is seen as a rising edge.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt;
    end
  end

  assign new_evt = (edge_mode & evt & ~evt_q) | (~edge_mode & evt);

endmodule

// File: rtl/irq_event_coalescer.sv
// Captures per-source events into a sticky W1C pending register and coalesces them into one-cycle
// status_o pulses by count threshold or timeout. Optional lost-event flags: IRQ_COAL_OVERFLOW_EN.
module irq_event_coalescer
  import irq_pkg::*;
#(
  parameter int SRC_W = SRC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             clk_i,
  input  logic             srst_n_i,
  input  logic [SRC_W-1:0] event_i,
  input  logic [SRC_W-1:0] edge_mode_i,
  input  logic [CNT_W-1:0] threshold_i,
  input  logic [TMO_W-1:0] timeout_i,
  // clr_valid_i is a single-cycle strobe with no back-pressure: clr_mask_i is applied in every
  // cycle clr_valid_i is high, and the register block never waits for an acknowledge.
  input  logic             clr_valid_i,
  input  logic [SRC_W-1:0] clr_mask_i,
  output logic [SRC_W-1:0] pending_o,
  output logic [SRC_W-1:0] status_o,
`ifdef IRQ_COAL_OVERFLOW_EN
  output logic [SRC_W-1:0] overflow_o,
`endif
  output logic [1:0]       coal_state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  logic [SRC_W-1:0] new_evt;
  logic [SRC_W-1:0] clr_bits;
  logic [SRC_W-1:0] pending_q;
  logic [SRC_W-1:0] acc_q;
  logic [CNT_W-1:0] ev_cnt_q;
  logic [CNT_W-1:0] ev_cnt_inc;
  logic [CNT_W-1:0] thr_eff;
  logic [TMO_W-1:0] timer_q;
  logic [TMO_W-1:0] timer_inc;
  logic [TMO_W-1:0] tmo_lim;
  logic             any_evt;
  logic             thr_hit;
  logic             tmo_hit;
  coal_state_t      state_q;
  coal_state_t      state_d;

  irq_edge_detect #(
    .W(SRC_W)
  ) u_edge (
    .clk      (clk_i),
    .srst_n   (srst_n_i),
    .evt      (event_i),
    .edge_mode(edge_mode_i),
    .new_evt  (new_evt)
  );

  assign any_evt  = |new_evt;
  assign clr_bits = clr_valid_i ? clr_mask_i : '0;

  // Pending: set has priority over a same-cycle W1C clear.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_bits) | new_evt;
    end
  end

  assign pending_o = pending_q;

`ifdef IRQ_COAL_OVERFLOW_EN
  logic [SRC_W-1:0] overflow_q;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      overflow_q <= '0;
    end else begin
      overflow_q <= (overflow_q & ~clr_bits) | (new_evt & pending_q & ~clr_bits);
    end
  end

  assign overflow_o = overflow_q;
`endif

  // Count check includes the current cycle's event so threshold 1 never waits an extra cycle.
  assign ev_cnt_inc = (any_evt && (ev_cnt_q != CNT_MAX)) ? ev_cnt_q + CNT_W'(1) : ev_cnt_q;
  assign thr_eff    = (threshold_i == '0) ? CNT_W'(1) : threshold_i;
  assign thr_hit    = (ev_cnt_inc >= thr_eff);

  assign timer_inc  = (timer_q == TMO_MAX) ? timer_q : timer_q + TMO_W'(1);
  assign tmo_lim    = timeout_i - TMO_W'(1);
  assign tmo_hit    = (timeout_i != '0) && (timer_q >= tmo_lim);

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_evt) state_d = ACCUM;
      ACCUM:   if (thr_hit || tmo_hit) state_d = EMIT;
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_o     = '0;
    coal_state_o = state_q;
    if (state_q == EMIT) begin
      status_o = acc_q | new_evt;
    end
  end

  // Events arriving during EMIT leave in that pulse, so acc restarts empty.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      acc_q    <= '0;
      ev_cnt_q <= '0;
      timer_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_evt) begin
            acc_q    <= new_evt;
            ev_cnt_q <= CNT_W'(1);
            timer_q  <= '0;
          end
        end
        ACCUM: begin
          acc_q    <= acc_q | new_evt;
          ev_cnt_q <= ev_cnt_inc;
          timer_q  <= timer_inc;
        end
        default: begin
          acc_q    <= '0;
          ev_cnt_q <= '0;
          timer_q  <= '0;
        end
      endcase
    end
  end

endmodule
